// File: rtl/dco_bank_pkg.sv
// ---------------------------------------------------------------------------
// dco_bank_pkg
//
// Shared definitions for the DCO capacitor-bank control path.
//   DCO_ROWS / DCO_COLS : default bank geometry (rows x columns)
//   DCO_WORD_W          : width of the binary tuning word for that geometry
//   row_vec_t/col_vec_t : row and column control vector types
//   is_therm()          : 1 when a vector is contiguous ones starting at bit 0
// ---------------------------------------------------------------------------
package dco_bank_pkg;

    localparam int DCO_ROWS   = 16;
    localparam int DCO_COLS   = 16;
    localparam int DCO_WORD_W = 8;

    // Widest vector is_therm() accepts; narrower vectors are zero-extended.
    localparam int THERM_MAX_W = 32;

    typedef logic [DCO_ROWS-1:0] row_vec_t;
    typedef logic [DCO_COLS-1:0] col_vec_t;

    // A thermometer code 0..01..1 has no set bit above a clear bit, so adding
    // one carries all the way through the ones and lands on a clear bit:
    // the AND of v and v+1 is zero exactly for contiguous-from-LSB patterns.
    // Zero-extension keeps the property, and the all-zero code is legal.
    function automatic logic is_therm(input logic [THERM_MAX_W-1:0] vec);
        logic [THERM_MAX_W-1:0] inc;
        inc = vec + THERM_MAX_W'(1);
        return ((vec & inc) == '0);
    endfunction

endpackage

// File: rtl/therm_dec.sv
// ---------------------------------------------------------------------------
// therm_dec
//
// Combinational thermometer-to-binary converter with a shape check.
//   therm  in  N   thermometer code, ones packed from bit 0 upward
//   count  out CW  number of set bits in therm (the binary value)
//   legal  out 1   1 when therm is contiguous ones from bit 0
//
// count is the plain popcount whether or not the code is legal; callers
// must qualify it with legal. N must not exceed dco_bank_pkg::THERM_MAX_W.
// ---------------------------------------------------------------------------
module therm_dec
    import dco_bank_pkg::*;
#(
    parameter int N  = 16,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  therm,
    output logic [CW-1:0] count,
    output logic          legal
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(therm[i]);
        end
    end

    assign legal = is_therm(THERM_MAX_W'(therm));

endmodule

// File: rtl/row_col_dec.sv
// ---------------------------------------------------------------------------
// row_col_dec
//
// Readback decoder for the DCO row/column capacitor-bank control codes.
// Recovers the binary tuning word COLS*R + C from the r_all/row/col vectors,
// checks the code is legal, counts illegal codes and reports when the
// decoded word has settled.
//
//   clk       in  1       bank/reference clock, rising edge
//   rst       in  1       asynchronous reset, active low
//   en        in  1       pipeline advance enable
//   r_all     in  ROWS    fully-on rows, thermometer from bit 0
//   row       in  ROWS    one-hot select of the partially filled row
//   col       in  COLS    column thermometer within the selected row
//   clr_err   in  1       synchronous clear of err_cnt
//   word      out WORD_W  last legally decoded tuning word
//   word_vld  out 1       word updated from a legal code this cycle
//   code_err  out 1       one-cycle pulse per illegal code
//   err_cnt   out ERR_W   saturating count of illegal codes
//   stable    out 1       word unchanged for STABLE_CYC legal decodes
//
// Pipeline: inputs are captured at edge t, decoded and checked at t+1, and
// the outputs update at t+2. en=0 freezes every stage.
// ---------------------------------------------------------------------------
module row_col_dec
    import dco_bank_pkg::*;
#(
    parameter int ROWS       = DCO_ROWS,
    parameter int COLS       = DCO_COLS,
    parameter int WORD_W     = DCO_WORD_W,
    parameter int STABLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ROWS-1:0]   r_all,
    input  logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    input  logic              clr_err,
    output logic [WORD_W-1:0] word,
    output logic              word_vld,
    output logic              code_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              stable
);

    localparam int RCW = $clog2(ROWS + 1);
    localparam int CCW = $clog2(COLS + 1);
    localparam int SCW = $clog2(STABLE_CYC + 1);

    // Stage 1: raw input capture
    logic              s1_vld_q, s1_vld_d;
    logic [ROWS-1:0]   r_all_q, r_all_d;
    logic [ROWS-1:0]   row_q, row_d;
    logic [COLS-1:0]   col_q, col_d;

    // Stage 2: decoded word and legality
    logic              s2_vld_q, s2_vld_d;
    logic              s2_legal_q, s2_legal_d;
    logic [WORD_W-1:0] s2_word_q, s2_word_d;

    // Output stage
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic              code_err_q, code_err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [SCW-1:0]    scnt_q, scnt_d;
    logic              stable_q, stable_d;

    // Decode of the stage-1 registers
    logic [RCW-1:0]    r_cnt;
    logic [CCW-1:0]    c_cnt;
    logic              r_therm_ok;
    logic              c_therm_ok;
    logic [ROWS-1:0]   row_sel;
    logic              dec_legal;
    logic [WORD_W-1:0] dec_word;
    logic              out_fire;

    therm_dec #(.N(ROWS)) u_r_dec (
        .therm (r_all_q),
        .count (r_cnt),
        .legal (r_therm_ok)
    );

    therm_dec #(.N(COLS)) u_c_dec (
        .therm (col_q),
        .count (c_cnt),
        .legal (c_therm_ok)
    );

    // Stage 1: take a new sample whenever the pipeline advances. The valid
    // bit keeps the all-zero post-reset contents from being decoded as an
    // illegal code.
    always_comb begin
        s1_vld_d = s1_vld_q;
        r_all_d  = r_all_q;
        row_d    = row_q;
        col_d    = col_q;
        if (en) begin
            s1_vld_d = 1'b1;
            r_all_d  = r_all;
            row_d    = row;
            col_d    = col;
        end
    end

    // Legality: the partial row must sit directly above the full rows, so
    // the only acceptable row vector is a single one at index R. Comparing
    // against that exact pattern checks one-hotness and position together.
    // R = ROWS (all rows full) and C = COLS (full partial row) are illegal
    // because a full row must be expressed by advancing R instead.
    always_comb begin
        row_sel   = ROWS'(1) << r_cnt;
        dec_legal = r_therm_ok
                 && (int'(r_cnt) <= ROWS - 1)
                 && (row_q == row_sel)
                 && c_therm_ok
                 && (int'(c_cnt) <= COLS - 1);
        dec_word  = WORD_W'(int'(r_cnt) * COLS + int'(c_cnt));
    end

    // Stage 2: register the decode result alongside the sample's valid bit
    always_comb begin
        s2_vld_d   = s2_vld_q;
        s2_legal_d = s2_legal_q;
        s2_word_d  = s2_word_q;
        if (en) begin
            s2_vld_d   = s1_vld_q;
            s2_legal_d = dec_legal;
            s2_word_d  = dec_word;
        end
    end

    assign out_fire = en && s2_vld_q;

    // Output stage. The stability counter compares the new legal word with
    // the word currently presented, so a repeat extends the run and a new
    // value restarts it at one. An error kills the run outright. The error
    // counter clear takes priority but still counts an error landing on the
    // same edge, so that error is never lost.
    always_comb begin
        word_d     = word_q;
        word_vld_d = 1'b0;
        code_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        scnt_d     = scnt_q;

        if (out_fire) begin
            if (s2_legal_q) begin
                word_d     = s2_word_q;
                word_vld_d = 1'b1;
                if (s2_word_q == word_q) begin
                    if (scnt_q != SCW'(STABLE_CYC)) begin
                        scnt_d = scnt_q + SCW'(1);
                    end
                end else begin
                    scnt_d = SCW'(1);
                end
            end else begin
                code_err_d = 1'b1;
                scnt_d     = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
        end

        if (clr_err) begin
            err_cnt_d = (out_fire && !s2_legal_q) ? ERR_W'(1) : '0;
        end

        stable_d = (scnt_d == SCW'(STABLE_CYC));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            r_all_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            s2_vld_q   <= 1'b0;
            s2_legal_q <= 1'b0;
            s2_word_q  <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            code_err_q <= 1'b0;
            err_cnt_q  <= '0;
            scnt_q     <= '0;
            stable_q   <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            r_all_q    <= r_all_d;
            row_q      <= row_d;
            col_q      <= col_d;
            s2_vld_q   <= s2_vld_d;
            s2_legal_q <= s2_legal_d;
            s2_word_q  <= s2_word_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            code_err_q <= code_err_d;
            err_cnt_q  <= err_cnt_d;
            scnt_q     <= scnt_d;
            stable_q   <= stable_d;
        end
    end

    assign word     = word_q;
    assign word_vld = word_vld_q;
    assign code_err = code_err_q;
    assign err_cnt  = err_cnt_q;
    assign stable   = stable_q;

endmodule

// File: tb/tb_row_col_dec.sv
// ---------------------------------------------------------------------------
// tb_row_col_dec
//
// Scoreboard bench for row_col_dec. The driver issues one code per enabled
// cycle and pushes the response a behavioural model predicts; a monitor pops
// and compares whenever the decoder presents word_vld or code_err.
// ---------------------------------------------------------------------------
module tb_row_col_dec;
    import dco_bank_pkg::*;

    localparam int ROWS       = DCO_ROWS;
    localparam int COLS       = DCO_COLS;
    localparam int WORD_W     = DCO_WORD_W;
    localparam int STABLE_CYC = 4;
    localparam int ERR_W      = 8;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              clr_err = 1'b0;
    row_vec_t          r_all = '0;
    row_vec_t          row = '0;
    col_vec_t          col = '0;
    logic [WORD_W-1:0] word;
    logic              word_vld;
    logic              code_err;
    logic [ERR_W-1:0]  err_cnt;
    logic              stable;

    always #5 clk = ~clk;

    row_col_dec #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .WORD_W     (WORD_W),
        .STABLE_CYC (STABLE_CYC),
        .ERR_W      (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .r_all    (r_all),
        .row      (row),
        .col      (col),
        .clr_err  (clr_err),
        .word     (word),
        .word_vld (word_vld),
        .code_err (code_err),
        .err_cnt  (err_cnt),
        .stable   (stable)
    );

    typedef struct {
        int word;
        bit vld;
        bit err;
        int ecnt;
        bit stable;
        bit lat_chk;
        int cap;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   en_edge = 1'b0;
    int   last_exp_word = 0;

    // Reference model state: what the decoder should present after each code
    int   m_word = 0;
    int   m_ecnt = 0;
    int   m_scnt = 0;
    bit   clr_h0 = 1'b0;
    bit   clr_h1 = 1'b0;
    int   last_ra = 0;
    int   last_rw = 1;
    int   last_cl = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_edge <= en;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // v is a legal thermometer of value k (0..w-1) iff it equals 2^k-1
    function automatic bit therm_val(input int v, input int w, output int k);
        k = 0;
        for (int i = 0; i < w; i++) begin
            if (v == (1 << i) - 1) begin
                k = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_code(input int ra, input int rw, input int cl,
                                       output bit legal, output int w);
        int r;
        int c;
        bit r_ok;
        bit c_ok;
        r_ok  = therm_val(ra, ROWS, r);
        c_ok  = therm_val(cl, COLS, c);
        legal = r_ok && c_ok && (rw == (1 << r));
        w     = COLS * r + c;
    endfunction

    // Issue one code with en=1. clr requests clr_err on the edge where this
    // code's result appears (two enabled edges later).
    task automatic apply_stimulus(input int ra, input int rw, input int cl,
                                  input bit clr, input bit lat);
        exp_t e;
        bit   legal;
        int   w;
        model_code(ra, rw, cl, legal, w);
        if (legal) begin
            if (w == m_word) m_scnt = (m_scnt < STABLE_CYC) ? m_scnt + 1 : STABLE_CYC;
            else m_scnt = 1;
            m_word = w;
            if (clr) m_ecnt = 0;
        end else begin
            m_scnt = 0;
            if (clr) m_ecnt = 1;
            else if (m_ecnt < ERR_MAX) m_ecnt = m_ecnt + 1;
        end
        e.word    = m_word;
        e.vld     = legal;
        e.err     = !legal;
        e.ecnt    = m_ecnt;
        e.stable  = (m_scnt == STABLE_CYC);
        e.lat_chk = lat;
        e.cap     = cyc + 1;
        sb.push_back(e);

        clr_err = clr_h1;
        clr_h1  = clr_h0;
        clr_h0  = clr;
        en      = 1'b1;
        r_all   = ROWS'(ra);
        row     = ROWS'(rw);
        col     = COLS'(cl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        en      = 1'b0;
        clr_err = 1'b0;
        repeat (n) begin
            r_all = ROWS'($urandom);
            row   = ROWS'($urandom);
            col   = COLS'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, int'(word), 0);
        check({tag, "_vld"}, int'(word_vld), 0);
        check({tag, "_err"}, int'(code_err), 0);
        check({tag, "_ecnt"}, int'(err_cnt), 0);
        check({tag, "_stable"}, int'(stable), 0);
    endtask

    task automatic reset_model();
        sb.delete();
        m_word        = 0;
        m_ecnt        = 0;
        m_scnt        = 0;
        clr_h0        = 1'b0;
        clr_h1        = 1'b0;
        last_exp_word = 0;
    endtask

    // Monitor: compare against the scoreboard whenever the decoder reports
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (!en_edge) begin
                check("hold_vld", int'(word_vld), 0);
                check("hold_err", int'(code_err), 0);
                check("hold_word", int'(word), last_exp_word);
            end
            if (word_vld || code_err) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_output: got word=%0d vld=%0b err=%0b, expected none",
                             word, word_vld, code_err);
                end else begin
                    e = sb.pop_front();
                    check("word", int'(word), e.word);
                    check("word_vld", int'(word_vld), int'(e.vld));
                    check("code_err", int'(code_err), int'(e.err));
                    check("err_cnt", int'(err_cnt), e.ecnt);
                    check("stable", int'(stable), int'(e.stable));
                    if (e.lat_chk) check("latency", cyc - e.cap, 2);
                    last_exp_word = e.word;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        int r;
        int c;
        int b;
        int wait_cnt;

        // Power-on reset
        #2 rst = 1'b0;
        #1 check_all_zero("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle_cycles(2);

        // Boundary words
        apply_stimulus(0, 16'h0001, 0, 1'b0, 1'b1);
        apply_stimulus(16'h00FF, 16'h0100, 0, 1'b0, 1'b1);
        apply_stimulus(16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1);

        // Illegal codes: column bubble, two-hot row, all rows full
        apply_stimulus(0, 16'h0001, 16'h0005, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0003, 0, 1'b0, 1'b1);
        apply_stimulus(16'hFFFF, 16'h8000, 0, 1'b0, 1'b1);

        // Stability: word 0, then 13 four times, then 14
        apply_stimulus(0, 16'h0001, 0, 1'b0, 1'b1);
        repeat (4) apply_stimulus(0, 16'h0001, 16'h1FFF, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0001, 16'h3FFF, 1'b0, 1'b1);

        // Clear landing on the same edge as an illegal decode
        apply_stimulus(0, 16'h0001, 16'h0005, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0001, 16'h0005, 1'b1, 1'b1);
        apply_stimulus(16'h0003, 16'h0004, 16'h000F, 1'b0, 1'b1);
        apply_stimulus(16'h0003, 16'h0004, 16'h000F, 1'b0, 1'b1);

        // Enable gap with two codes in flight
        apply_stimulus(16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
        idle_cycles(5);
        apply_stimulus(16'h0007, 16'h0008, 0, 1'b0, 1'b1);

        // Randomized mix of new, repeated and corrupted codes
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4 || kind >= 8) begin
                r = $urandom_range(0, ROWS - 1);
                c = $urandom_range(0, COLS - 1);
                last_ra = (1 << r) - 1;
                last_rw = 1 << r;
                last_cl = (1 << c) - 1;
            end
            if (kind >= 8) begin
                b = $urandom_range(0, 15);
                case ($urandom_range(0, 2))
                    0:       apply_stimulus(last_ra ^ (1 << b), last_rw, last_cl, ($urandom_range(0, 15) == 0), 1'b1);
                    1:       apply_stimulus(last_ra, last_rw ^ (1 << b), last_cl, ($urandom_range(0, 15) == 0), 1'b1);
                    default: apply_stimulus(last_ra, last_rw, last_cl ^ (1 << b), ($urandom_range(0, 15) == 0), 1'b1);
                endcase
            end else begin
                apply_stimulus(last_ra, last_rw, last_cl, ($urandom_range(0, 15) == 0), 1'b1);
            end
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(0, 16'h0001, 16'h0005, 1'b0, 1'b1);
        end
        apply_stimulus(0, 16'h0001, 16'h0002, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0001, 16'h0002, 1'b0, 1'b1);

        // Asynchronous reset mid-stream
        apply_stimulus(16'h000F, 16'h0010, 16'h00FF, 1'b0, 1'b1);
        apply_stimulus(16'h001F, 16'h0020, 16'h00FF, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_rst");
        reset_model();
        en      = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle_cycles(2);
        apply_stimulus(16'h003F, 16'h0040, 16'h0007, 1'b0, 1'b1);
        apply_stimulus(16'h003F, 16'h0040, 16'h0007, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0001, 16'h0005, 1'b0, 1'b1);

        // Two trailing codes push the last real result out; they stay queued
        apply_stimulus(0, 16'h0001, 0, 1'b0, 1'b1);
        apply_stimulus(0, 16'h0001, 0, 1'b0, 1'b1);
        en = 1'b0;
        wait_cnt = 0;
        while (sb.size() > 2 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        idle_cycles(3);
        check("drain_left", sb.size(), 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/row_col_dec.md
Name: row_col_dec

Overview:
- Decoder for the row/column capacitor-bank control codes that drive the DCO medium and small banks.
- Takes the registered r_all/row/col vectors and recovers the binary tuning word.
- Checks that the code is legal, counts illegal codes, and flags when the decoded word has settled.
- Used as a readback/monitor beside the DCO, so loop and bench logic can confirm which tuning word the bank is actually applying.

Parameters:
- ROWS, 16, number of bank rows; width of r_all and row
- COLS, 16, number of bank columns; width of col
- WORD_W, 8, decoded word width; equals log2(ROWS*COLS)
- STABLE_CYC, 4, consecutive identical legal decodes required to assert stable
- ERR_W, 8, width of the saturating illegal-code counter

Ports:
- clk  in  1  bank/reference clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  pipeline advance enable
- r_all  in  ROWS  rows fully on, thermometer LSB-first
- row  in  ROWS  one-hot partially-filled row select
- col  in  COLS  column thermometer (LSB-first) within the selected row
- clr_err  in  1  synchronous clear of err_cnt
- word  out  WORD_W  decoded tuning word = COLS*R + C
- word_vld  out  1  word updated from a legal code this cycle
- code_err  out  1  one-cycle pulse per illegal code decoded
- err_cnt  out  ERR_W  saturating count of illegal codes
- stable  out  1  decoded word unchanged for STABLE_CYC legal decodes

Behaviour:
- Reset (rst=0, asynchronous): all outputs and internal registers go to 0 immediately. Any sample in flight is discarded.
- Stage 1 (edge t, en=1): register r_all, row and col.
- Stage 2 (edge t+1, en=1): decode and check legality. Outputs update at edge t+2. Latency is 2 cycles.
- With en=0: both stages hold, word_vld=0, code_err=0, and the stable counter holds.
- Legality rules:
  - r_all is contiguous ones from bit 0. R = popcount(r_all), with R <= ROWS-1.
  - row is exactly one-hot, with the set bit at index R.
  - col is contiguous ones from bit 0. C = popcount(col), with C <= COLS-1; all-ones col is illegal.
- Legal code: word <= COLS*R + C, computed at WORD_W width with no overflow possible. word_vld=1 and code_err=0.
- Illegal code:
  - word holds its previous value, word_vld=0, code_err=1 for one cycle.
  - err_cnt increments and saturates at 2^ERR_W-1.
- clr_err=1 sets err_cnt to 0. If clr_err and an illegal decode land on the same edge, err_cnt becomes 1.
- Stability counter (saturates at STABLE_CYC):
  - A legal decode equal to the current word increments the counter.
  - A legal decode that differs from it loads 1.
  - An illegal decode loads 0.
  - stable = (counter == STABLE_CYC). It drops on the same edge a change or error is registered.
- Back-to-back legal codes every cycle are supported; there are no bubbles.

Decomposition:
- Package dco_bank_pkg holds:
  - constants DCO_ROWS=16, DCO_COLS=16 and DCO_WORD_W=8
  - typedefs row_vec_t and col_vec_t
  - function is_therm(vec), returning 1 for contiguous ones from LSB
- Sub-module therm_dec (parameter N): combinational thermometer-to-binary conversion with a legal flag. Instantiated once for r_all and once for col.
- One-hot check and position compare stay inline in row_col_dec.

Test Plan:
- Word 0: r_all=0, row=0x0001, col=0 with en=1 -> word=0, word_vld=1 two cycles later, code_err=0.
- Words 128 and 255:
  - r_all=0x00FF, row=0x0100, col=0 -> word=128.
  - r_all=0x7FFF, row=0x8000, col=0x7FFF -> word=255.
- Illegal codes:
  - col=0x0005 (bubble) -> code_err pulses once, word holds the prior value, err_cnt +1.
  - row=0x0003 -> same response.
  - r_all=0xFFFF -> same response.
- Stability: hold word 13 (r_all=0, row=0x0001, col=0x1FFF) -> stable=1 exactly at the 4th legal decode. Change to 14 -> stable=0 on the next output edge.
- Counter clear and saturation:
  - clr_err on the same edge as an illegal decode -> err_cnt=1.
  - 300 consecutive illegal codes with ERR_W=8 -> err_cnt=255.
- Reset and enable:
  - rst=0 mid-stream -> all outputs 0 asynchronously. After release, the first word_vld comes 2 enabled cycles after the next sample.
  - en=0 -> word holds and word_vld=0.
